// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues PC-ordered word requests to instruction
// memory, buffers in-order responses in a prefetch FIFO and handles redirects.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        n_rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        busy
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]   r_fpc;
   logic [31:0]   r_rpc;
   logic [CW-1:0] r_inflight;
   logic [CW-1:0] r_drop;
   logic [CW-1:0] r_count;
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [31:0]   r_pc_mem   [DEPTH];
   logic [31:0]   r_word_mem [DEPTH];

   logic          w_accept;
   logic          w_rsp;
   logic          w_push;
   logic          w_pop;
   logic [CW:0]   w_occ;
   logic [31:0]   w_redirect_pc;

   always_comb begin
      w_occ         = {1'b0, r_inflight} + {1'b0, r_count};
      w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
      // Credit rule: in-flight plus buffered words never exceed the FIFO size.
      imem_req_valid = n_rst && !redirect_valid && (w_occ < (CW+1)'(DEPTH));
      imem_req_addr  = r_fpc;
      w_accept       = imem_req_valid && imem_req_ready;
      w_rsp          = imem_rsp_valid && (r_inflight != '0);
      w_push         = w_rsp && (r_drop == '0) && !redirect_valid;
      instr_valid    = (r_count != '0) && !redirect_valid;
      w_pop          = instr_valid && instr_ready;
      instr          = instr_valid ? r_word_mem[r_rd_ptr] : NOP;
      instr_pc       = instr_valid ? r_pc_mem[r_rd_ptr] : r_rpc;
      busy           = (r_inflight != '0);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_fpc      <= RESET_PC;
         r_rpc      <= RESET_PC;
         r_inflight <= '0;
         r_drop     <= '0;
         r_count    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
      end else begin
         case ({w_accept, w_rsp})
            2'b10:   r_inflight <= r_inflight + CW'(1);
            2'b01:   r_inflight <= r_inflight - CW'(1);
            default: r_inflight <= r_inflight;
         endcase

         if (redirect_valid) begin
            // Everything still outstanding after this edge belongs to the old path.
            r_fpc    <= w_redirect_pc;
            r_rpc    <= w_redirect_pc;
            r_drop   <= r_inflight - CW'(w_rsp);
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_accept)
               r_fpc <= r_fpc + 32'd4;
            if (w_rsp && (r_drop != '0))
               r_drop <= r_drop - CW'(1);
            if (w_push) begin
               r_rpc    <= r_rpc + 32'd4;
               r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop)
               r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CW'(1);
               2'b01:   r_count <= r_count - CW'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr]   <= r_rpc;
         r_word_mem[r_wr_ptr] <= imem_rsp_data;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-configurable memory model feeds
// responses, and every accepted request queues the word decode should see.
module tb_fetch_unit;

   localparam int unsigned DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] TAG      = 32'hA000_0000;

   logic        clk;
   logic        n_rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        busy;

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr (imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data (imem_rsp_data),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } mreq_t;

   int          n_tests;
   int          n_fail;
   logic [63:0] exp_q [$];
   mreq_t       mem_q [$];
   logic [31:0] acc_log [$];
   int unsigned cyc;
   int unsigned lat;
   logic [31:0] exp_addr;
   int unsigned n_pop;
   int          first_valid_cyc;
   logic [31:0] first_pop_pc;
   bit          got_first_pop;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      mem_q.delete();
      acc_log.delete();
      exp_addr        = RESET_PC;
      cyc             = 0;
      n_pop           = 0;
      first_valid_cyc = -1;
      first_pop_pc    = 32'hDEAD_BEEF;
      got_first_pop   = 1'b0;
   endtask

   task automatic mark();
      acc_log.delete();
      first_pop_pc  = 32'hDEAD_BEEF;
      got_first_pop = 1'b0;
      n_pop         = 0;
   endtask

   function automatic logic [31:0] acc_at(input int unsigned i);
      return (acc_log.size() > i) ? acc_log[i] : 32'hDEAD_BEEF;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_valid"}, 64'(imem_req_valid), 64'(0));
      check({tag, "_instr_valid"}, 64'(instr_valid), 64'(0));
      check({tag, "_instr"}, 64'(instr), 64'(32'h0000_0013));
      check({tag, "_instr_pc"}, 64'(instr_pc), 64'(RESET_PC));
      check({tag, "_busy"}, 64'(busy), 64'(0));
   endtask

   // One clock: sample handshakes mid-cycle, then update the models after the edge.
   task automatic tick();
      logic        s_acc, s_pop, s_rsp, s_redir;
      logic [31:0] s_addr, s_pc, s_instr, s_rpc;
      @(negedge clk);
      s_acc   = imem_req_valid && imem_req_ready;
      s_addr  = imem_req_addr;
      s_pop   = instr_valid && instr_ready;
      s_pc    = instr_pc;
      s_instr = instr;
      s_rsp   = imem_rsp_valid;
      s_redir = redirect_valid;
      s_rpc   = redirect_pc;
      if (s_redir) begin
         check("redirect_no_req", 64'(imem_req_valid), 64'(0));
         check("redirect_no_valid", 64'(instr_valid), 64'(0));
      end
      if (instr_valid && first_valid_cyc < 0)
         first_valid_cyc = int'(cyc);
      @(posedge clk);
      #1;
      cyc++;
      if (s_pop) begin
         n_pop++;
         if (!got_first_pop) begin
            first_pop_pc  = s_pc;
            got_first_pop = 1'b1;
         end
         if (exp_q.size() == 0)
            check("pop_unexpected", 64'(exp_q.size()), 64'(1));
         else
            check("pop", {s_pc, s_instr}, exp_q.pop_front());
      end
      if (s_redir) begin
         exp_q.delete();
         exp_addr = s_rpc & 32'hFFFF_FFFC;
      end
      if (s_acc) begin
         check("req_addr", 64'(s_addr), 64'(exp_addr));
         exp_addr = exp_addr + 32'd4;
         acc_log.push_back(s_addr);
         mem_q.push_back('{addr: s_addr, due: cyc + lat - 1});
         exp_q.push_back({s_addr, s_addr | TAG});
      end
      if (s_rsp && mem_q.size() > 0)
         void'(mem_q.pop_front());
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_q[0].addr | TAG;
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end
   endtask

   task automatic do_reset();
      n_rst          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      model_clear();
      n_rst = 1'b1;
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      tick();
      redirect_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests        = 0;
      n_fail         = 0;
      lat            = 1;
      n_rst          = 1'b0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      instr_ready    = 1'b1;
      model_clear();
      #12;
      check_reset_outputs("reset");

      // Reset then stream
      do_reset();
      repeat (20) tick();
      check("stream_first_valid", 64'(first_valid_cyc), 64'(2));
      check("stream_first_pc", 64'(first_pop_pc), 64'(0));
      check("stream_pops", 64'(n_pop >= 5), 64'(1));

      // Backpressure
      instr_ready = 1'b0;
      do_reset();
      repeat (10) tick();
      check("bp_req_count", 64'(acc_log.size()), 64'(2));
      check("bp_fifo_count", 64'(dut.r_count), 64'(2));
      check("bp_req_valid", 64'(imem_req_valid), 64'(0));
      instr_ready = 1'b1;
      mark();
      repeat (10) tick();
      check("bp_first_pc", 64'(first_pop_pc), 64'(0));
      check("bp_resume_addr", 64'(acc_at(0)), 64'(32'h8));

      // Redirect with in-flight drops
      lat = 3;
      do_reset();
      repeat (2) tick();
      check("rd_inflight", 64'(dut.r_inflight), 64'(2));
      mark();
      redirect_to(32'h0000_0102);
      check("rd_drop", 64'(dut.r_drop), 64'(2));
      repeat (15) tick();
      check("rd_next_addr", 64'(acc_at(0)), 64'(32'h100));
      check("rd_first_pc", 64'(first_pop_pc), 64'(32'h100));

      // Redirect, response and pop in the same cycle
      lat = 1;
      do_reset();
      repeat (2) tick();
      check("sim_pre_count", 64'(dut.r_count), 64'(1));
      check("sim_pre_inflight", 64'(dut.r_inflight), 64'(1));
      mark();
      redirect_to(32'h0000_0200);
      check("sim_count", 64'(dut.r_count), 64'(0));
      check("sim_drop", 64'(dut.r_drop), 64'(0));
      check("sim_busy", 64'(busy), 64'(0));
      repeat (8) tick();
      check("sim_first_pc", 64'(first_pop_pc), 64'(32'h200));

      // Request stall
      imem_req_ready = 1'b0;
      redirect_to(32'h0000_0040);
      repeat (3) tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_valid", 64'(imem_req_valid), 64'(1));
         check("stall_addr", 64'(imem_req_addr), 64'(32'h40));
         check("stall_inflight", 64'(dut.r_inflight), 64'(0));
      end
      imem_req_ready = 1'b1;
      mark();
      repeat (10) tick();
      check("stall_first_pc", 64'(first_pop_pc), 64'(32'h40));

      // Address wrap
      mark();
      redirect_to(32'hFFFF_FFFC);
      repeat (10) tick();
      check("wrap_addr0", 64'(acc_at(0)), 64'(32'hFFFF_FFFC));
      check("wrap_addr1", 64'(acc_at(1)), 64'(32'h0));
      check("wrap_first_pc", 64'(first_pop_pc), 64'(32'hFFFF_FFFC));

      // Asynchronous reset mid-stream, then a stale response after release
      repeat (3) tick();
      @(negedge clk);
      #2;
      n_rst = 1'b0;
      #1;
      check_reset_outputs("async");
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0BAD_0BAD;
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      check("stale_count", 64'(dut.r_count), 64'(0));
      check("stale_busy", 64'(busy), 64'(0));
      model_clear();
      imem_req_ready = 1'b1;
      repeat (10) tick();
      check("post_reset_first_pc", 64'(first_pop_pc), 64'(RESET_PC));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
